// File: rtl/rv_core_pkg.sv
// Shared core definitions: architectural sizes and the register index type
// used by the write-back arbiter and its scoreboard.
package rv_core_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, marking
// destinations still owned by the multi-cycle unit.
// Ports:
//   clk, reset          clock, async active-high reset (clears all bits)
//   set_en / set_idx    mark a register busy at the next edge
//   clr_en / clr_idx    mark a register free at the next edge
//   look_idx[2:0]       three combinational lookups (rs1, rs2, rd)
//   look_busy[2:0]      busy bit for each lookup
//   busy_vec            full scoreboard state
module rf_scoreboard
  import rv_core_pkg::*;
#(
  parameter int NREG = rv_core_pkg::NREG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  reg_idx_t [2:0]      look_idx,
  output logic     [2:0]      look_busy,
  output logic     [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy;

  // Set and clear never target the same index (the issue stall prevents a
  // WAW against a pending entry), so their order here only matters for x0,
  // which is forced back to zero last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (set_en) busy[set_idx] <= 1'b1;
      if (clr_en) busy[clr_idx] <= 1'b0;
      busy[0] <= 1'b0;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_look
    assign look_busy[i] = busy[look_idx[i]];
  end

  assign busy_vec = busy;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port.
// Port A (pipeline write-back) has fixed priority and never stalls; port B
// (multi-cycle unit) uses valid/ready. Destinations pending in port B are
// tracked in a scoreboard and issue stalls on RAW/WAW hazards against them.
// A starvation counter forces issue to stall once B has waited STARVE_LIMIT
// cycles, so the pipeline drains and B gets the port.
// Ports:
//   clk, reset                     clock, async active-high reset
//   issue_*                        decode/issue request, issue_stall back
//   a_valid/a_rd/a_data            pipeline write-back
//   b_valid/b_rd/b_data, b_ready   multi-cycle result handshake
//   reg_we/rd/wd                   register file write port
//   busy_vec                       scoreboard state
module rf_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int XLEN         = rv_core_pkg::XLEN,
  parameter int NREG         = rv_core_pkg::NREG,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  reg_idx_t        issue_rd,
  input  reg_idx_t        issue_rs1,
  input  reg_idx_t        issue_rs2,
  output logic            issue_stall,
  input  logic            a_valid,
  input  reg_idx_t        a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  input  reg_idx_t        b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            reg_we,
  output reg_idx_t        rd,
  output logic [XLEN-1:0] wd,
  output logic [NREG-1:0] busy_vec
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          a_occ, b_xfer, haz, starve, accept;
  logic [2:0]    look_busy;
  logic [CW-1:0] wait_cnt;

  // x0 writes are dropped, so an A request to x0 leaves the port free for B.
  assign a_occ  = a_valid && (a_rd != REG_ZERO);
  assign b_xfer = b_valid && b_ready;

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (accept && issue_long),
    .set_idx   (issue_rd),
    .clr_en    (b_xfer),
    .clr_idx   (b_rd),
    .look_idx  ({issue_rd, issue_rs2, issue_rs1}),
    .look_busy (look_busy),
    .busy_vec  (busy_vec)
  );

  assign haz         = |look_busy;
  assign starve      = (wait_cnt == CW'(STARVE_LIMIT));
  assign issue_stall = !reset && issue_valid && (haz || starve);
  assign accept      = issue_valid && !issue_stall;

  // Write-port mux; everything is forced quiet while reset is asserted.
  always_comb begin
    reg_we  = 1'b0;
    rd      = REG_ZERO;
    wd      = '0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_occ) begin
        reg_we = 1'b1;
        rd     = a_rd;
        wd     = a_data;
      end else begin
        b_ready = 1'b1;
        if (b_valid && (b_rd != REG_ZERO)) begin
          reg_we = 1'b1;
          rd     = b_rd;
          wd     = b_data;
        end
      end
    end
  end

  // Counts cycles B is held off by A; saturates so starve stays asserted
  // until B actually transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (b_xfer) begin
      wait_cnt <= '0;
    end else if (b_valid && !b_ready && !starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A must never target a register still owned by the multi-cycle unit.
  a_not_busy: assert property (@(posedge clk) disable iff (reset)
    !(a_occ && busy_vec[a_rd]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        reg_we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] busy_vec;

  int checks = 0;
  int failures = 0;

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .reg_we(reg_we), .rd(rd), .wd(wd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
  endtask

  // Issues one long instruction writing r with no source hazards.
  task automatic issue_long_rd(input logic [4:0] r);
    issue_valid = 1; issue_long = 1; issue_rd = r; issue_rs1 = 0; issue_rs2 = 0;
    #1;
    checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL issue_long x%0d stall got=%0b exp=0", r, issue_stall); end
    step();
    issue_valid = 0; issue_long = 0; issue_rd = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    a_valid = 1; a_rd = 3; a_data = 32'h1234;
    b_valid = 1; b_rd = 4; issue_valid = 1; issue_rs1 = 5;
    #1;
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL reset reg_we got=%0b exp=0", reg_we); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL reset b_ready got=%0b exp=0", b_ready); end
    checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL reset issue_stall got=%0b exp=0", issue_stall); end
    checks++; if (rd !== 5'd0 || wd !== 32'd0) begin failures++; $display("FAIL reset rd/wd got=%0d/%h exp=0/0", rd, wd); end
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL reset busy_vec got=%h exp=0", busy_vec); end
    step(); step();
    idle();
    reset = 0;
    step();
  endtask

  task automatic test_raw();
    issue_long_rd(5);
    checks++; if (busy_vec !== 32'h20) begin failures++; $display("FAIL raw busy_vec got=%h exp=20", busy_vec); end
    issue_valid = 1; issue_long = 0; issue_rd = 6; issue_rs1 = 5; issue_rs2 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL raw_wait%0d stall got=%0b exp=1", k, issue_stall); end
      step();
    end
    b_valid = 1; b_rd = 5; b_data = 32'hdeadbeef;
    #1;
    checks++; if (b_ready !== 1'b1 || reg_we !== 1'b1) begin failures++; $display("FAIL raw_xfer ready/we got=%0b/%0b exp=1/1", b_ready, reg_we); end
    checks++; if (rd !== 5'd5 || wd !== 32'hdeadbeef) begin failures++; $display("FAIL raw_xfer rd/wd got=%0d/%h exp=5/deadbeef", rd, wd); end
    checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL raw_xfer stall got=%0b exp=1", issue_stall); end
    step();
    b_valid = 0;
    #1;
    checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL raw_release stall got=%0b exp=0", issue_stall); end
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL raw_release busy_vec got=%h exp=0", busy_vec); end
    step();
    idle();
  endtask

  task automatic test_priority();
    issue_long_rd(7);
    a_valid = 1; a_rd = 3; a_data = 32'h33;
    b_valid = 1; b_rd = 7; b_data = 32'h77;
    #1;
    checks++; if (reg_we !== 1'b1 || rd !== 5'd3 || wd !== 32'h33) begin failures++; $display("FAIL prio_a we/rd/wd got=%0b/%0d/%h exp=1/3/33", reg_we, rd, wd); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL prio_a b_ready got=%0b exp=0", b_ready); end
    step();
    a_valid = 0;
    #1;
    checks++; if (b_ready !== 1'b1 || reg_we !== 1'b1 || rd !== 5'd7 || wd !== 32'h77) begin failures++; $display("FAIL prio_b ready/we/rd/wd got=%0b/%0b/%0d/%h exp=1/1/7/77", b_ready, reg_we, rd, wd); end
    step();
    b_valid = 0;
    #1;
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL prio_clear busy_vec got=%h exp=0", busy_vec); end
    idle();
  endtask

  task automatic test_zero_rd();
    issue_long_rd(4);
    issue_long_rd(8);
    a_valid = 1; a_rd = 0; a_data = 32'h1111;
    b_valid = 1; b_rd = 4; b_data = 32'h44;
    #1;
    checks++; if (b_ready !== 1'b1 || reg_we !== 1'b1 || rd !== 5'd4 || wd !== 32'h44) begin failures++; $display("FAIL a_x0 ready/we/rd/wd got=%0b/%0b/%0d/%h exp=1/1/4/44", b_ready, reg_we, rd, wd); end
    step();
    a_valid = 0; b_rd = 0; b_data = 32'h99;
    #1;
    checks++; if (reg_we !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL b_x0 we/ready got=%0b/%0b exp=0/1", reg_we, b_ready); end
    checks++; if (rd !== 5'd0 || wd !== 32'd0) begin failures++; $display("FAIL b_x0 rd/wd got=%0d/%h exp=0/0", rd, wd); end
    step();
    b_valid = 0;
    #1;
    checks++; if (busy_vec !== 32'h100) begin failures++; $display("FAIL b_x0 busy_vec got=%h exp=100", busy_vec); end
    b_valid = 1; b_rd = 8; b_data = 32'h88;
    step();
    b_valid = 0;
    #1;
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL clr_x8 busy_vec got=%h exp=0", busy_vec); end
    idle();
  endtask

  task automatic test_starve();
    issue_long_rd(10);
    a_valid = 1; a_rd = 11; a_data = 32'hab;
    b_valid = 1; b_rd = 10; b_data = 32'hcd;
    issue_valid = 1; issue_long = 0; issue_rd = 12; issue_rs1 = 1; issue_rs2 = 2;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (issue_stall !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL starve_cnt%0d stall/ready got=%0b/%0b exp=0/0", k, issue_stall, b_ready); end
      step();
    end
    // counter at limit with A still occupying: stall holds, counter saturates
    #1;
    checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL starve_limit stall got=%0b exp=1", issue_stall); end
    step();
    a_valid = 0;
    #1;
    checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL starve_sat stall got=%0b exp=1", issue_stall); end
    checks++; if (reg_we !== 1'b1 || rd !== 5'd10 || wd !== 32'hcd) begin failures++; $display("FAIL starve_grant we/rd/wd got=%0b/%0d/%h exp=1/10/cd", reg_we, rd, wd); end
    step();
    b_valid = 0;
    #1;
    checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL starve_clear stall got=%0b exp=0", issue_stall); end
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL starve_clear busy_vec got=%h exp=0", busy_vec); end
    idle();
    step();
  endtask

  task automatic test_set_clear();
    issue_long_rd(6);
    issue_valid = 1; issue_long = 1; issue_rd = 2; issue_rs1 = 0; issue_rs2 = 0;
    b_valid = 1; b_rd = 6; b_data = 32'h66;
    #1;
    checks++; if (issue_stall !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL setclr stall/ready got=%0b/%0b exp=0/1", issue_stall, b_ready); end
    step();
    issue_valid = 0; issue_long = 0; b_valid = 0;
    #1;
    checks++; if (busy_vec !== 32'h4) begin failures++; $display("FAIL setclr busy_vec got=%h exp=4", busy_vec); end
    issue_valid = 1; issue_long = 0; issue_rd = 2;
    b_valid = 1; b_rd = 2; b_data = 32'h22;
    #1;
    checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL waw_xfer stall got=%0b exp=1", issue_stall); end
    checks++; if (reg_we !== 1'b1 || rd !== 5'd2) begin failures++; $display("FAIL waw_xfer we/rd got=%0b/%0d exp=1/2", reg_we, rd); end
    step();
    b_valid = 0;
    #1;
    checks++; if (issue_stall !== 1'b0 || busy_vec !== 32'd0) begin failures++; $display("FAIL waw_release stall/busy got=%0b/%h exp=0/0", issue_stall, busy_vec); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    issue_long_rd(5);
    issue_long_rd(9);
    checks++; if (busy_vec !== 32'h220) begin failures++; $display("FAIL rmid_pre busy_vec got=%h exp=220", busy_vec); end
    reset = 1;
    a_valid = 1; a_rd = 3; a_data = 32'h5;
    b_valid = 1; b_rd = 5; issue_valid = 1; issue_rs1 = 5;
    #1;
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL rmid busy_vec got=%h exp=0", busy_vec); end
    checks++; if (reg_we !== 1'b0 || issue_stall !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL rmid we/stall/ready got=%0b/%0b/%0b exp=0/0/0", reg_we, issue_stall, b_ready); end
    step();
    idle();
    reset = 0;
    #1;
    checks++; if (busy_vec !== 32'd0 || issue_stall !== 1'b0) begin failures++; $display("FAIL rmid_after busy/stall got=%h/%0b exp=0/0", busy_vec, issue_stall); end
    step();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_priority();
    test_zero_rd();
    test_starve();
    test_set_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and register scoreboard in front of the 32×32 register file's single write port. Shares that port between the in-order pipeline write-back (port A, never stalls) and the multi-cycle unit (port B, load/divide, valid/ready). Tracks destinations pending in the multi-cycle unit and stalls issue on RAW/WAW hazards against them. Sits between the decode/issue stage, the two result sources and `reg_file`.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; x0 hard-wired zero.
- `STARVE_LIMIT`, 8: port-B wait cycles before issue is forced to stall.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_long`  in  1  instruction completes through port B.
- `issue_rd`, `issue_rs1`, `issue_rs2`  in  5 each  destination and sources.
- `issue_stall`  out  1  instruction must not issue this cycle.
- `a_valid`  in  1  pipeline write-back request.
- `a_rd`  in  5, `a_data`  in  XLEN.
- `b_valid`  in  1  multi-cycle result available.
- `b_rd`  in  5, `b_data`  in  XLEN.
- `b_ready`  out  1  port-B result consumed this cycle.
- `reg_we`  out  1, `rd`  out  5, `wd`  out  XLEN  to `reg_file`.
- `busy_vec`  out  NREG  scoreboard state (debug/perf).

## Operation
- Scoreboard `busy[NREG]`, bit 0 constant 0.
- Hazard: `haz` = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd] (indices 0 never busy).
- `issue_stall` = issue_valid & (haz | starve).
- Issue accepted = issue_valid & !issue_stall. If accepted & issue_long & issue_rd≠0: set busy[issue_rd] at next edge.
- Arbitration, fixed priority to A: A "occupies" port iff a_valid & a_rd≠0.
  - A occupies: reg_we=1, rd=a_rd, wd=a_data, b_ready=0.
  - Else: b_ready=1; reg_we = b_valid & b_rd≠0, rd=b_rd, wd=b_data.
  - Idle (no write): reg_we=0, rd=0, wd=0.
- Handshake on B: transfer = b_valid & b_ready; clears busy[b_rd] at next edge. b_ready may be high with b_valid low; the B unit holds b_rd/b_data stable until transfer.
- b_rd=0: transfer completes, no write, no scoreboard change.
- Starvation counter `wait_cnt` (width clog2(STARVE_LIMIT+1)): +1 each cycle b_valid & !b_ready, saturates at STARVE_LIMIT, cleared on transfer. `starve` = (wait_cnt == STARVE_LIMIT); pipeline then drains and B is granted.
- Simultaneous set and clear of same index cannot occur: a busy rd stalls issue (WAW). Set and clear of different indices in one cycle both take effect.
- A writing a busy register is a protocol violation (prevented by the stall); assertion only, no recovery.

## Timing
- `reg_we`/`rd`/`wd`/`b_ready`/`issue_stall` combinational from inputs and state; zero-latency path into `reg_file`, which writes at the same edge.
- Scoreboard and counter update on rising clk; hazard visible to issue one cycle after acceptance.
- Busy bit cleared at the edge where the B write lands; dependent instruction issues the following cycle and reads the new value.
- Reset: busy_vec=0, wait_cnt=0, starve=0; while reset high, reg_we=0, b_ready=0, issue_stall=0, rd=0, wd=0 regardless of inputs. Reset mid-operation drops all pending entries; the B unit is reset together.

## Structure
- Shared package `rv_core_pkg`: `XLEN`, `NREG`, `reg_idx_t` (logic [4:0]), `REG_ZERO` constant.
- Sub-module `rf_scoreboard`: busy vector, set/clear ports, three combinational lookup ports. The arbiter mux and starvation counter stay in the top.

## Test plan
- Reset mid-run with busy[5],busy[9] set -> busy_vec=0, reg_we=0, issue_stall=0 immediately.
- Issue long rd=x5; next cycle issue rs1=x5 -> issue_stall=1 until the B transfer for x5, released the cycle after; reg_we=1, rd=5 on the transfer cycle.
- a_valid,a_rd=3 and b_valid,b_rd=7 together -> rd=3 written, b_ready=0; next cycle (A idle) b_ready=1, rd=7 written, busy[7] cleared.
- A with rd=0 and b_valid,b_rd=4 -> B granted, reg_we=1, rd=4; b_rd=0 transfer -> reg_we=0, b_ready=1, no scoreboard change.
- A valid with rd≠0 for 8 cycles while b_valid -> wait_cnt=8, issue_stall=1 for any issue_valid; after A drains, B transfers and wait_cnt=0.
- Same-cycle issue long rd=x2 and B transfer x6 -> next cycle busy[2]=1, busy[6]=0; issue with rd=x6 same cycle as its transfer -> stalled one cycle.
